// File: rtl/bwu_pkg.sv
// Shared definitions for the pipelined bitwise unit: op codes, op type and
// the single-bit evaluation function applied across every operand bit.
package bwu_pkg;

    typedef logic [2:0] bwu_op_t;

    localparam bwu_op_t BWU_NOT  = 3'd0;
    localparam bwu_op_t BWU_AND  = 3'd1;
    localparam bwu_op_t BWU_OR   = 3'd2;
    localparam bwu_op_t BWU_XOR  = 3'd3;
    localparam bwu_op_t BWU_NAND = 3'd4;
    localparam bwu_op_t BWU_NOR  = 3'd5;
    localparam bwu_op_t BWU_XNOR = 3'd6;
    localparam bwu_op_t BWU_PASS = 3'd7;

    // Evaluate one result bit; ops are strictly bitwise so the unit applies
    // this independently to every bit position.
    function automatic logic bwu_eval(input bwu_op_t op, input logic a, input logic b);
        logic r;
        case (op)
            BWU_NOT:  r = ~a;
            BWU_AND:  r = a & b;
            BWU_OR:   r = a | b;
            BWU_XOR:  r = a ^ b;
            BWU_NAND: r = ~(a & b);
            BWU_NOR:  r = ~(a | b);
            BWU_XNOR: r = ~(a ^ b);
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bitwise_unit_stage.sv
// One pipeline register slice: valid/data/zero (and ones count when
// BWU_POPCOUNT_EN is defined). Loads the upstream beat whenever adv is high.
// Ports: clk, rst_n, adv, in_valid/in_data/in_zero[/in_ones] from upstream,
//        out_valid/out_data/out_zero[/out_ones] registered slice contents.
module bitwise_unit_stage #(
    parameter int unsigned WIDTH = 16
`ifdef BWU_POPCOUNT_EN
    , parameter int unsigned OW  = 5
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_zero,
`ifdef BWU_POPCOUNT_EN
    input  logic [OW-1:0]    in_ones,
    output logic [OW-1:0]    out_ones,
`endif
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Slice register; a bubble upstream loads as valid=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_zero  <= 1'b0;
`ifdef BWU_POPCOUNT_EN
            out_ones  <= '0;
`endif
        end else if (adv) begin
            out_valid <= in_valid;
            out_data  <= in_data;
            out_zero  <= in_zero;
`ifdef BWU_POPCOUNT_EN
            out_ones  <= in_ones;
`endif
        end
    end

endmodule

// File: rtl/bitwise_unit_pipe.sv
// Pipelined bitwise logic unit: computes one of eight bitwise ops on WIDTH-bit
// operands and carries the result through DEPTH register stages with full
// valid/ready backpressure. Optional macro BWU_POPCOUNT_EN adds out_ones.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b/in_op (operand beat);
//        out_valid/out_ready/out_data/out_zero[/out_ones] (result beat); busy.
module bitwise_unit_pipe
    import bwu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
`ifdef BWU_POPCOUNT_EN
    output logic [$clog2(WIDTH+1)-1:0] out_ones,
`endif
    output logic             busy
);

`ifdef BWU_POPCOUNT_EN
    localparam int unsigned OW = $clog2(WIDTH + 1);
`endif

    logic [WIDTH-1:0] res_c;
    logic             zero_c;

    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] valid_s;
    logic [DEPTH-1:0] up_valid;
    logic [WIDTH-1:0] data_s  [DEPTH];
    logic [WIDTH-1:0] up_data [DEPTH];
    logic [DEPTH-1:0] zero_s;
    logic [DEPTH-1:0] up_zero;
`ifdef BWU_POPCOUNT_EN
    logic [OW-1:0]    ones_c;
    logic [OW-1:0]    ones_s  [DEPTH];
    logic [OW-1:0]    up_ones [DEPTH];
`endif

    // Bitwise result and flags computed at the input, captured by stage 0.
    always_comb begin
        res_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            res_c[i] = bwu_eval(bwu_op_t'(in_op), in_a[i], in_b[i]);
        end
        zero_c = ~|res_c;
    end

`ifdef BWU_POPCOUNT_EN
    // Population count of the result, piped alongside data.
    always_comb begin
        ones_c = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ones_c = ones_c + OW'(res_c[i]);
        end
    end
`endif

    // Advance chain from the output back to the input: a stage may load when
    // it is empty or the stage ahead of it is advancing.
    always_comb begin
        logic a;
        adv = '0;
        a   = !valid_s[DEPTH-1] || out_ready;
        adv[DEPTH-1] = a;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            a      = !valid_s[k] || a;
            adv[k] = a;
        end
    end

    // Upstream source for each stage: the input for stage 0, else stage k-1.
    always_comb begin
        up_valid[0] = in_valid;
        up_data[0]  = res_c;
        up_zero[0]  = zero_c;
`ifdef BWU_POPCOUNT_EN
        up_ones[0]  = ones_c;
`endif
        for (int k = 1; k < int'(DEPTH); k++) begin
            up_valid[k] = valid_s[k-1];
            up_data[k]  = data_s[k-1];
            up_zero[k]  = zero_s[k-1];
`ifdef BWU_POPCOUNT_EN
            up_ones[k]  = ones_s[k-1];
`endif
        end
    end

    for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
        bitwise_unit_stage #(
            .WIDTH (WIDTH)
`ifdef BWU_POPCOUNT_EN
            , .OW  (OW)
`endif
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv[k]),
            .in_valid  (up_valid[k]),
            .in_data   (up_data[k]),
            .in_zero   (up_zero[k]),
`ifdef BWU_POPCOUNT_EN
            .in_ones   (up_ones[k]),
            .out_ones  (ones_s[k]),
`endif
            .out_valid (valid_s[k]),
            .out_data  (data_s[k]),
            .out_zero  (zero_s[k])
        );
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_s[DEPTH-1];
    assign out_data  = data_s[DEPTH-1];
    assign out_zero  = zero_s[DEPTH-1];
`ifdef BWU_POPCOUNT_EN
    assign out_ones  = ones_s[DEPTH-1];
`endif
    assign busy      = |valid_s;

endmodule

// File: tb/tb_bitwise_unit_pipe.sv
// Scoreboard bench for bitwise_unit_pipe (WIDTH=16, DEPTH=2). Checks out_ones
// too when BWU_POPCOUNT_EN is defined.
module tb_bitwise_unit_pipe;
    import bwu_pkg::*;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned OW    = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic [OW-1:0]    ones;
        int               cyc;
        bit               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
`ifdef BWU_POPCOUNT_EN
    logic [OW-1:0]    out_ones;
`endif
    logic             busy;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    bitwise_unit_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
`ifdef BWU_POPCOUNT_EN
        .out_ones  (out_ones),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whole-word operators straight from the op table.
    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0: return ~a;
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return a ^ b;
            3'd4: return ~(a & b);
            3'd5: return ~(a | b);
            3'd6: return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Drive one cycle; expectation is queued only when the beat transfers.
    task automatic drive(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [2:0] op, input bit ordy, input bit lat,
                         input bit use_res, input logic [WIDTH-1:0] res, output bit acc);
        exp_t e;
        @(negedge clk);
        out_ready = ordy;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.data = use_res ? res : model(op, a, b);
            e.zero = (e.data == '0);
            e.ones = OW'($countones(e.data));
            e.cyc  = cyc;
            e.lat  = lat;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        drive(1'b0, '0, '0, 3'd0, ordy, 1'b0, 1'b0, '0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 100) begin
            idle(1'b1);
            n++;
        end
        check("drain_timeout", 32'(exp_q.size() != 0 || busy), 32'd0);
    endtask

    // Monitor: compare each transferred output beat against the queue head,
    // and check hold stability while stalled.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 32'(out_data), 32'hDEAD_0000);
            end else if (out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_zero", 32'(out_zero), 32'(e.zero));
`ifdef BWU_POPCOUNT_EN
                check("out_ones", 32'(out_ones), 32'(e.ones));
`endif
                if (e.lat) check("latency", 32'(cyc - e.cyc), 32'(DEPTH));
            end else begin
                check("stall_hold", 32'(out_data), 32'(exp_q[0].data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] tbl [8];
        logic [WIDTH-1:0] bp_a [5];
        bit acc;
        int idx;
        int ov_cnt;
        logic [5:0] pat;

        tbl[0] = 16'h0F0F; tbl[1] = 16'hF000; tbl[2] = 16'hFFF0; tbl[3] = 16'h0FF0;
        tbl[4] = 16'h0FFF; tbl[5] = 16'h000F; tbl[6] = 16'hF00F; tbl[7] = 16'hF0F0;

        // Reset / idle
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // All ops back to back with known results and latency
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'hF0F0, 16'hFF00, 3'(i), 1'b1, 1'b1, 1'b1, tbl[i], acc);
            check("ops_accept", 32'(acc), 32'd1);
        end
        drain();

        // Zero flag (and popcount of all-ones)
        drive(1'b1, 16'h00FF, 16'hFF00, BWU_AND, 1'b1, 1'b1, 1'b1, 16'h0000, acc);
        drive(1'b1, 16'h0000, 16'h1234, BWU_NOT, 1'b1, 1'b1, 1'b1, 16'hFFFF, acc);
        drain();

        // Backpressure: only DEPTH beats absorbed while out_ready is low
        for (int i = 0; i < 5; i++) bp_a[i] = 16'(16'h1111 * (i + 1));
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, bp_a[idx], 16'h0, BWU_PASS, 1'b0, 1'b0, 1'b0, '0, acc);
            if (acc) idx++;
        end
        check("bp_accepts", 32'(idx), 32'(DEPTH));
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_data", 32'(out_data), 32'(bp_a[0]));
        ov_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (idx < 5) begin
                drive(1'b1, bp_a[idx], 16'h0, BWU_PASS, 1'b1, 1'b0, 1'b0, '0, acc);
                if (acc) idx++;
            end else begin
                idle(1'b1);
            end
            if (out_valid) ov_cnt++;
        end
        check("bp_all_accepted", 32'(idx), 32'd5);
        check("bp_no_gaps", 32'(ov_cnt), 32'd5);
        drain();

        // Bubbles: in_valid 1,0,1 -> out_valid 1,0,1 delayed by DEPTH
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            drive(i == 0 || i == 2, 16'(16'hA5A5 + i), 16'h5A5A, BWU_XOR, 1'b1, 1'b1, 1'b0, '0, acc);
            pat[i] = out_valid;
        end
        check("bubble_pattern", 32'(pat), 32'b010100);
        drain();

        // Randomised traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'b0, 1'b0, '0, acc);
        end
        drain();

        // Mid-stream reset discards in-flight beats
        drive(1'b1, 16'h1234, 16'h00FF, BWU_OR, 1'b0, 1'b0, 1'b0, '0, acc);
        drive(1'b1, 16'h4321, 16'h00FF, BWU_OR, 1'b0, 1'b0, 1'b0, '0, acc);
        check("mr_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr_in_ready", 32'(in_ready), 32'd1);
        repeat (6) idle(1'b1);
        check("mr_idle_busy", 32'(busy), 32'd0);

        // Post-reset traffic still flows
        drive(1'b1, 16'hBEEF, 16'hFFFF, BWU_XNOR, 1'b1, 1'b1, 1'b0, '0, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
